// File: rtl/hazard_detect_pkg.sv
// Shared ISA constants and decode bundles for hazard
// detection; also imported by the control unit.
package hazard_detect_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100011;

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic       valid_wr;
        logic [4:0] dst;
        logic       is_load;
        logic       is_beq;
    } iclass_t;

    typedef struct packed {
        logic       valid_wr;
        logic [4:0] dst;
        logic       is_load;
    } shadow_t;

    localparam shadow_t SHADOW_EMPTY = '0;

    // A used, non-zero source that the shadow entry writes.
    function automatic logic src_hit(
        input logic       used,
        input logic [4:0] src,
        input shadow_t    s
    );
        return used && (src != 5'd0) &&
               s.valid_wr && (s.dst == src);
    endfunction

endpackage

// File: rtl/hazard_detect_if.sv
// ID-stage hazard handshake: instruction/flush in,
// write enables and bubble count out.
interface hazard_detect_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_instr;
    logic             flush;
    logic             PC_Write;
    logic             IFID_Write;
    logic             Control_Write;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_instr,
        output flush,
        input  PC_Write,
        input  IFID_Write,
        input  Control_Write,
        input  stall_cycles
    );

    modport slave (
        input  id_instr,
        input  flush,
        output PC_Write,
        output IFID_Write,
        output Control_Write,
        output stall_cycles
    );
endinterface

// File: rtl/hazard_detect_instr_class.sv
// Classifies a raw instruction into source use and
// writer info; unknown encodings become no-ops.
module instr_class
    import hazard_detect_pkg::*;
(
    input  logic [31:0] instr_i,
    output iclass_t     cls_o
);
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dst;
    logic       wr;
    logic       unused_bits;

    assign op          = instr_i[31:26];
    assign rt          = instr_i[20:16];
    assign rd          = instr_i[15:11];
    assign func        = instr_i[5:0];
    assign unused_bits = ^instr_i[10:6];

    // Opcode/func decode into the class bundle.
    always_comb begin
        cls_o = '0;
        dst   = 5'd0;
        wr    = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (func == FN_ADD || func == FN_SUB) begin
                    cls_o.uses_rs = 1'b1;
                    cls_o.uses_rt = 1'b1;
                    wr            = 1'b1;
                    dst           = rd;
                end
            end
            OP_ORI: begin
                cls_o.uses_rs = 1'b1;
                wr            = 1'b1;
                dst           = rt;
            end
            OP_LW: begin
                cls_o.uses_rs = 1'b1;
                cls_o.is_load = 1'b1;
                wr            = 1'b1;
                dst           = rt;
            end
            OP_SW: begin
                cls_o.uses_rs = 1'b1;
                cls_o.uses_rt = 1'b1;
            end
            OP_BEQ: begin
                cls_o.uses_rs = 1'b1;
                cls_o.uses_rt = 1'b1;
                cls_o.is_beq  = 1'b1;
            end
            OP_LUI: begin
                wr  = 1'b1;
                dst = rt;
            end
            default: ;
        endcase
        // Writes to $0 are discarded, so never a producer.
        cls_o.valid_wr = wr && (dst != 5'd0);
        cls_o.dst      = dst;
    end
endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard unit: tracks EX/MEM writers and
// inserts load-use and branch-operand bubbles.
module hazard_detect
    import hazard_detect_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    hazard_detect_if.slave hz
);
    localparam logic [CNT_W-1:0] CNT_ONE =
        {{(CNT_W-1){1'b0}}, 1'b1};

    iclass_t          id_cls;
    shadow_t          ex_q, ex_d;
    shadow_t          mem_q, mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rs, rt;
    logic             ex_hit, mem_hit;
    logic             load_use, br_haz;
    logic             stall, ctrl_wr;

    instr_class u_cls (
        .instr_i (hz.id_instr),
        .cls_o   (id_cls)
    );

    assign rs = hz.id_instr[25:21];
    assign rt = hz.id_instr[20:16];

    // Source matching against shadows and stall decision.
    always_comb begin
        ex_hit   = src_hit(id_cls.uses_rs, rs, ex_q) |
                   src_hit(id_cls.uses_rt, rt, ex_q);
        mem_hit  = src_hit(id_cls.uses_rs, rs, mem_q) |
                   src_hit(id_cls.uses_rt, rt, mem_q);
        load_use = ex_q.is_load & ex_hit;
        br_haz   = id_cls.is_beq &
                   (ex_hit | (mem_q.is_load & mem_hit));
        stall    = (load_use | br_haz) & ~hz.flush;
        ctrl_wr  = ~(stall | hz.flush);
    end

    assign hz.PC_Write      = ~stall;
    assign hz.IFID_Write    = ~stall;
    assign hz.Control_Write = ctrl_wr;
    assign hz.stall_cycles  = cnt_q;

    // Shadow advance and saturating bubble count.
    always_comb begin
        mem_d = ex_q;
        ex_d  = SHADOW_EMPTY;
        if (ctrl_wr) begin
            ex_d.valid_wr = id_cls.valid_wr;
            ex_d.dst      = id_cls.dst;
            ex_d.is_load  = id_cls.is_load;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= SHADOW_EMPTY;
            mem_q <= SHADOW_EMPTY;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 Parameter CNT_W, default 16: width of the bubble statistics counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_instr  input  32  raw instruction held in the IF/ID register.
REQ-005 flush  input  1  kills the ID instruction this cycle (taken beq or j resolved upstream).
REQ-006 PC_Write  output  1  1 = PC may advance; 0 = hold PC.
REQ-007 IFID_Write  output  1  1 = IF/ID may load; 0 = hold IF/ID.
REQ-008 Control_Write  output  1  0 = control unit zeroes all ID/EX control signals (bubble); 1 = pass decoded controls.
REQ-009 stall_cycles  output  CNT_W  count of hazard bubbles inserted since reset.

Function
REQ-010 The block shall decode id_instr internally: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], func=[5:0]; supported set add, sub, ori, lw, sw, beq, lui, j; any other encoding is treated as a no-op (no sources, no writer).
REQ-011 Source use: add/sub/beq/sw read rs and rt; ori/lw read rs; lui/j read none.
REQ-012 Writer: add/sub write rd; ori/lw/lui write rt; a writer with destination register 0 shall be recorded as a non-writer.
REQ-013 The block shall hold two shadow entries, EX and MEM, each {valid_wr, dst[4:0], is_load}, describing the instructions currently in the EX and MEM stages.
REQ-014 Load-use hazard: EX.valid_wr & EX.is_load & EX.dst matches any used source of the ID instruction -> stall.
REQ-015 Branch hazard (ID is beq): EX.valid_wr & EX.dst matches rs or rt -> stall; MEM.valid_wr & MEM.is_load & MEM.dst matches rs or rt -> stall.
REQ-016 Source register 0 shall never match.
REQ-017 stall = (REQ-014 | REQ-015) & ~flush; outputs are combinational, same cycle: PC_Write = IFID_Write = ~stall; Control_Write = ~(stall | flush).
REQ-018 Each clock edge: MEM <= EX; EX <= ID writer info when Control_Write=1, else EX <= empty (valid_wr=0).
REQ-019 Latency: load followed by dependent ALU/sw instruction = 1 bubble; ALU writer followed by dependent beq = 1 bubble; load followed by dependent beq = 2 consecutive bubbles; stall re-evaluates every cycle from shadows, with no stored stall count.
REQ-020 stall_cycles shall increment by 1 on every edge where stall=1, saturating at 2^CNT_W-1; flush-only bubbles are not counted.
REQ-021 flush has priority over stall: with flush=1, PC_Write=1, IFID_Write=1, Control_Write=0, and EX receives a bubble.

Reset
REQ-022 While reset=1 at an edge: EX and MEM entries emptied, stall_cycles=0.
REQ-023 Immediately after reset, PC_Write=1, IFID_Write=1, and Control_Write=1 for any id_instr.
REQ-024 Reset asserted mid-stall shall end the stall on the next cycle; no residual bubble follows.

Structure
REQ-025 Opcode/func constants (6'b000000 R-type, 6'b100011 lw, 6'b101011 sw, 6'b000100 beq, 6'b001101 ori, 6'b001111 lui, 6'b000010 j, func 6'b100001 add, 6'b100011 sub) shall live in a shared package/include used by both this block and the control unit.
REQ-026 One sub-module, instr_class, shall map a 32-bit instruction to {uses_rs, uses_rt, valid_wr, dst, is_load, is_beq}.

Verification
REQ-027 lw $1,0($2) then add $3,$1,$4 -> exactly 1 cycle with PC_Write=IFID_Write=Control_Write=0; stall_cycles=1.
REQ-028 add $1,$2,$3 then beq $1,$2 -> 1 bubble; ori $1 then beq $5,$6 -> 0 bubbles.
REQ-029 lw $1,0($2) then beq $1,$0 -> 2 consecutive bubbles; stall_cycles=2.
REQ-030 lw $0,0($2) then add $3,$0,$0 -> no stall; lui $1 then lw $4,0($1) -> no stall (ALU forwarding).
REQ-031 lw $1 then add $3,$1,$4 with flush=1 in the add cycle -> PC_Write=1, IFID_Write=1, Control_Write=0, stall_cycles unchanged.
REQ-032 reset=1 during the second bubble of the lw/beq case -> next cycle all three write enables=1, stall_cycles=0; CNT_W=2 with 5 stalls -> stall_cycles holds at 3.
